cram_ctrl: RTL and testbench
============================

CRAM_CTRL -- requirements
Module: cram_ctrl

Interface
REQ-001 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-002 Parameter DATA_W, 16, RAM data width; SHALL be 8 or 16. BE_W = DATA_W/8.
REQ-003 Parameter ADDR_W, 23, RAM word-address width.
REQ-004 Parameter ACCESS_CYC, 7, clk cycles in the ACCESS state; SHALL be at least 2.
REQ-005 Parameter RECOVER_CYC, 1, clk cycles with chip disabled between accesses; SHALL be at least 1.
REQ-006 Ports SHALL be:
- clk in 1 system clock
- rst in 1 sync reset
- req in 1 access request
- we in 1 1=write, 0=read
- cfg in 1 1=configuration-register write via CRE
- be in BE_W byte enables, active-high
- addr in ADDR_W word address, or config value when cfg=1
- wdata in DATA_W write data
- rdata out DATA_W read data
- rvalid out 1 one-cycle read-data strobe
- busy out 1 access in progress
- mt_addr out ADDR_W RAM address
- mt_dq_i in DATA_W RAM data in
- mt_dq_o out DATA_W RAM data out
- mt_dq_oe out 1 tristate enable for mt_dq (top level resolves the pad)
- mt_clk out 1 held 0 (asynchronous mode)
- mt_adv_n out 1 address valid
- mt_ce_n out 1 chip enable
- mt_oe_n out 1 output enable
- mt_we_n out 1 write enable
- mt_be_n out BE_W byte lanes (lb/ub when DATA_W=16)
- mt_cre out 1 control-register enable
- mt_wait in 1 ignored in asynchronous mode

Function
REQ-007 States SHALL be IDLE, SETUP, ACCESS and RECOVER; busy SHALL equal (state != IDLE).
REQ-008 A request SHALL be accepted on a clk edge where req=1 and state=IDLE; addr, we, cfg, be and wdata SHALL be registered at that edge.
REQ-009 IDLE->SETUP SHALL occur on acceptance; SETUP SHALL last 1 cycle with mt_ce_n=0, mt_adv_n=0 and mt_addr valid.
REQ-010 ACCESS SHALL last exactly ACCESS_CYC cycles with mt_adv_n=1, mt_ce_n=0, and mt_addr held.
REQ-011 RECOVER SHALL last RECOVER_CYC cycles with mt_ce_n=mt_oe_n=mt_we_n=1, mt_be_n all 1, mt_dq_oe=0; RECOVER->IDLE SHALL follow.
REQ-012 For reads, mt_oe_n=0 SHALL hold in SETUP and ACCESS, mt_we_n=1, mt_dq_oe=0, mt_be_n=~be.
REQ-013 For reads, rdata SHALL capture mt_dq_i on the edge that ends the last ACCESS cycle, and rvalid SHALL be 1 for exactly the following cycle. This gives rvalid in the cycle after edge ACCESS_CYC+1, counted from the acceptance edge as edge 0.
REQ-014 For writes, mt_we_n=0, mt_dq_oe=1, mt_dq_o=wdata and mt_be_n=~be SHALL hold in SETUP and ACCESS; mt_oe_n=1 and rvalid=0.
REQ-015 When cfg=1, the access SHALL be a write with mt_cre=1 in SETUP and ACCESS, mt_be_n all 1, mt_dq_oe=0, and mt_addr=addr; we and be SHALL be ignored.
REQ-016 When be is all zero and cfg=0, the request SHALL be accepted without a RAM cycle: mt_ce_n stays 1, the next state is IDLE, and a read SHALL still pulse rvalid 1 cycle after acceptance with rdata unchanged.
REQ-017 req held continuously SHALL issue back-to-back accesses every 1+ACCESS_CYC+RECOVER_CYC+1 cycles; req while busy SHALL be ignored, not queued.
REQ-018 mt_clk SHALL be constant 0; mt_wait SHALL have no effect.
REQ-019 All RAM-side outputs SHALL be registered (glitch-free).

Reset
REQ-020 On an edge with rst=1, the block SHALL take these values regardless of state:
- state=IDLE
- mt_ce_n=mt_oe_n=mt_we_n=mt_adv_n=1
- mt_be_n all 1
- mt_cre=0, mt_dq_oe=0
- mt_addr=0, mt_dq_o=0
- rdata=0, rvalid=0, busy=0
- cycle counter=0
REQ-021 Reset mid-access SHALL abort the access with no rvalid; a request with req=1 during rst SHALL not be accepted.

Structure
REQ-022 The state encoding, default timing constants and the parameter-legality check SHALL live in shared package cram_pkg.
REQ-023 The ACCESS and RECOVER down-counter SHALL be sub-module cram_cnt (load, decrement, zero flag); everything else SHALL be flat.

Verification
REQ-024 The bench SHALL cover these scenarios (default parameters):
- Read: req=1, we=0, be=11, addr=0x012345; mt_dq_i=0xBEEF -> mt_oe_n low 8 cycles, rvalid 1 cycle after edge 8, rdata=0xBEEF.
- Write: we=1, be=01, wdata=0xA55A -> mt_be_n=10, mt_we_n low 8 cycles, mt_dq_oe high exactly those cycles, no rvalid.
- Config: cfg=1, addr=0x081D1F -> mt_cre=1 with mt_addr=0x081D1F, mt_be_n=11, mt_dq_oe=0.
- Back-to-back: req held 3 accesses -> accepted every 10 cycles, mt_ce_n high ≥1 cycle between.
- Mid-access reset: rst at ACCESS cycle 3 -> next edge all outputs at reset values, no rvalid.
- Zero byte-enable read: be=00 -> mt_ce_n stays 1, rvalid 1 cycle after acceptance.
- Parameter sweep: repeat the read with ACCESS_CYC=2, RECOVER_CYC=3 and with DATA_W=8.

Source files
------------

// File: rtl/cram_pkg.sv
// Shared definitions for the CellularRAM asynchronous-mode controller.
// Holds the FSM state encoding, default timing constants, the parameter
// legality check and the counter-width helper used by cram_ctrl.
package cram_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSetup   = 2'd1,
        StAccess  = 2'd2,
        StRecover = 2'd3
    } cram_state_e;

    localparam int unsigned DEF_DATA_W      = 16;
    localparam int unsigned DEF_ADDR_W      = 23;
    localparam int unsigned DEF_ACCESS_CYC  = 7;
    localparam int unsigned DEF_RECOVER_CYC = 1;

    function automatic bit params_ok(input int unsigned data_w,
                                     input int unsigned access_cyc,
                                     input int unsigned recover_cyc);
        return ((data_w == 8) || (data_w == 16)) && (access_cyc >= 2) && (recover_cyc >= 1);
    endfunction

    // The down-counter is loaded with (cycles - 1), so it only has to reach
    // max(access, recover) - 1.
    function automatic int unsigned cnt_width(input int unsigned access_cyc,
                                              input int unsigned recover_cyc);
        int unsigned max_v;
        max_v = (access_cyc > recover_cyc) ? access_cyc : recover_cyc;
        return (max_v < 2) ? 1 : $clog2(max_v);
    endfunction

endpackage

// File: rtl/cram_cnt.sv
// Phase down-counter for the ACCESS and RECOVER states.
// Ports:
//   clk, rst   - clock, synchronous active-high reset (clears the count)
//   load       - load load_val (has priority over dec)
//   load_val   - value loaded, normally (phase length - 1)
//   dec        - decrement by one, saturating at zero
//   zero       - count is zero: the current cycle is the last of its phase
module cram_cnt #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/cram_ctrl.sv
// Asynchronous-mode CellularRAM controller.
// A request accepted in IDLE runs SETUP (1 cycle, address latched by ADV#),
// ACCESS (ACCESS_CYC cycles) and RECOVER (RECOVER_CYC cycles, chip disabled).
// cfg=1 turns the access into a control-register write through CRE.
// Ports:
//   clk, rst             - clock, synchronous active-high reset
//   req/we/cfg/be/addr/wdata - request side, sampled on acceptance
//   rdata/rvalid/busy    - read data, one-cycle read strobe, access in progress
//   mt_*                 - RAM pins; all driven from registers
module cram_ctrl
    import cram_pkg::*;
#(
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned ACCESS_CYC  = DEF_ACCESS_CYC,
    parameter int unsigned RECOVER_CYC = DEF_RECOVER_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic                  cfg,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  busy,
    output logic [ADDR_W-1:0]     mt_addr,
    input  logic [DATA_W-1:0]     mt_dq_i,
    output logic [DATA_W-1:0]     mt_dq_o,
    output logic                  mt_dq_oe,
    output logic                  mt_clk,
    output logic                  mt_adv_n,
    output logic                  mt_ce_n,
    output logic                  mt_oe_n,
    output logic                  mt_we_n,
    output logic [DATA_W/8-1:0]   mt_be_n,
    output logic                  mt_cre,
    input  logic                  mt_wait
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = cnt_width(ACCESS_CYC, RECOVER_CYC);
    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(RECOVER_CYC - 1);

    if (!params_ok(DATA_W, ACCESS_CYC, RECOVER_CYC)) begin : g_bad_params
        $error("cram_ctrl: illegal DATA_W / ACCESS_CYC / RECOVER_CYC");
    end

    cram_state_e       state_q, state_d;
    logic              we_q, we_d, cfg_q, cfg_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dq_o_q, dq_o_d;
    logic              dq_oe_q, dq_oe_d, adv_n_q, adv_n_d, ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d, we_n_q, we_n_d, cre_q, cre_d;
    logic [BE_W-1:0]   be_n_q, be_n_d;

    logic              accept, ram_cycle, in_cycle;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val;

    cram_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_comb begin
        accept       = req && (state_q == StIdle);
        // With no byte lane enabled there is nothing to move: skip the RAM cycle.
        ram_cycle    = accept && (cfg || (be != '0));
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ram_cycle) state_d = StSetup;
            end
            StSetup: begin
                state_d      = StAccess;
                cnt_load     = 1'b1;
                cnt_load_val = ACC_LOAD;
            end
            StAccess: begin
                if (cnt_zero) begin
                    state_d      = StRecover;
                    cnt_load     = 1'b1;
                    cnt_load_val = REC_LOAD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StRecover: begin
                if (cnt_zero) state_d = StIdle;
                else          cnt_dec = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // Request fields and next pin values. Pins are computed from the next
    // state so that the registered outputs line up with the state register.
    always_comb begin
        we_d    = we_q;
        cfg_d   = cfg_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (accept) begin
            we_d    = we | cfg;  // a config access is always a write
            cfg_d   = cfg;
            be_d    = be;
            wdata_d = wdata;
        end

        addr_d   = ram_cycle ? addr : addr_q;
        dq_o_d   = dq_o_q;
        dq_oe_d  = 1'b0;
        ce_n_d   = 1'b1;
        adv_n_d  = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        cre_d    = 1'b0;
        be_n_d   = '1;
        in_cycle = (state_d == StSetup) || (state_d == StAccess);

        if (in_cycle) begin
            ce_n_d  = 1'b0;
            adv_n_d = (state_d != StSetup);
            if (cfg_d) begin
                we_n_d = 1'b0;
                cre_d  = 1'b1;
            end else if (we_d) begin
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
                dq_o_d  = wdata_d;
                be_n_d  = ~be_d;
            end else begin
                oe_n_d = 1'b0;
                be_n_d = ~be_d;
            end
        end

        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if ((state_q == StAccess) && cnt_zero && !we_q) begin
            rdata_d  = mt_dq_i;
            rvalid_d = 1'b1;
        end else if (accept && !ram_cycle && !we) begin
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            cfg_q    <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            addr_q   <= '0;
            dq_o_q   <= '0;
            dq_oe_q  <= 1'b0;
            adv_n_q  <= 1'b1;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            we_n_q   <= 1'b1;
            cre_q    <= 1'b0;
            be_n_q   <= '1;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            cfg_q    <= cfg_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            addr_q   <= addr_d;
            dq_o_q   <= dq_o_d;
            dq_oe_q  <= dq_oe_d;
            adv_n_q  <= adv_n_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            cre_q    <= cre_d;
            be_n_q   <= be_n_d;
        end
    end

    // WAIT is only meaningful in synchronous burst mode.
    logic unused_wait;
    assign unused_wait = mt_wait;

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign busy     = (state_q != StIdle);
    assign mt_addr  = addr_q;
    assign mt_dq_o  = dq_o_q;
    assign mt_dq_oe = dq_oe_q;
    assign mt_clk   = 1'b0;
    assign mt_adv_n = adv_n_q;
    assign mt_ce_n  = ce_n_q;
    assign mt_oe_n  = oe_n_q;
    assign mt_we_n  = we_n_q;
    assign mt_be_n  = be_n_q;
    assign mt_cre   = cre_q;

endmodule

// File: tb/tb_cram_ctrl.sv
// Bench for cram_ctrl: three instances (defaults; ACCESS_CYC=2/RECOVER_CYC=3;
// DATA_W=8) share one stimulus stream. A timeline model (cycles since
// acceptance) predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_cram_ctrl;

    logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, cfg = 1'b0, mt_wait = 1'b0;
    logic [1:0]  be = 2'b00;
    logic [22:0] addr = '0;
    logic [15:0] wdata = '0, dq_i = '0;

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [15:0] o_rdata [3];
    logic [15:0] o_dq_o  [3];
    logic [22:0] o_addr  [3];
    logic [1:0]  o_be_n  [3];
    logic        o_rvalid[3], o_busy[3], o_dq_oe[3], o_clk[3], o_adv_n[3];
    logic        o_ce_n  [3], o_oe_n[3], o_we_n[3], o_cre[3];
    logic [7:0]  r2, q2;
    logic        b2;

    cram_ctrl u_dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .cfg(cfg), .be(be), .addr(addr),
        .wdata(wdata), .rdata(o_rdata[0]), .rvalid(o_rvalid[0]), .busy(o_busy[0]),
        .mt_addr(o_addr[0]), .mt_dq_i(dq_i), .mt_dq_o(o_dq_o[0]), .mt_dq_oe(o_dq_oe[0]),
        .mt_clk(o_clk[0]), .mt_adv_n(o_adv_n[0]), .mt_ce_n(o_ce_n[0]), .mt_oe_n(o_oe_n[0]),
        .mt_we_n(o_we_n[0]), .mt_be_n(o_be_n[0]), .mt_cre(o_cre[0]), .mt_wait(mt_wait)
    );

    cram_ctrl #(.ACCESS_CYC(2), .RECOVER_CYC(3)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .we(we), .cfg(cfg), .be(be), .addr(addr),
        .wdata(wdata), .rdata(o_rdata[1]), .rvalid(o_rvalid[1]), .busy(o_busy[1]),
        .mt_addr(o_addr[1]), .mt_dq_i(dq_i), .mt_dq_o(o_dq_o[1]), .mt_dq_oe(o_dq_oe[1]),
        .mt_clk(o_clk[1]), .mt_adv_n(o_adv_n[1]), .mt_ce_n(o_ce_n[1]), .mt_oe_n(o_oe_n[1]),
        .mt_we_n(o_we_n[1]), .mt_be_n(o_be_n[1]), .mt_cre(o_cre[1]), .mt_wait(mt_wait)
    );

    cram_ctrl #(.DATA_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .req(req), .we(we), .cfg(cfg), .be(be[0]), .addr(addr),
        .wdata(wdata[7:0]), .rdata(r2), .rvalid(o_rvalid[2]), .busy(o_busy[2]),
        .mt_addr(o_addr[2]), .mt_dq_i(dq_i[7:0]), .mt_dq_o(q2), .mt_dq_oe(o_dq_oe[2]),
        .mt_clk(o_clk[2]), .mt_adv_n(o_adv_n[2]), .mt_ce_n(o_ce_n[2]), .mt_oe_n(o_oe_n[2]),
        .mt_we_n(o_we_n[2]), .mt_be_n(b2), .mt_cre(o_cre[2]), .mt_wait(mt_wait)
    );

    assign o_rdata[2] = {8'h00, r2};
    assign o_dq_o[2]  = {8'h00, q2};
    assign o_be_n[2]  = {1'b1, b2};

    function automatic int acc_of(input int i);
        return (i == 1) ? 2 : 7;
    endfunction
    function automatic int rec_of(input int i);
        return (i == 1) ? 3 : 1;
    endfunction
    function automatic logic [15:0] dmask(input int i);
        return (i == 2) ? 16'h00FF : 16'hFFFF;
    endfunction
    function automatic logic [1:0] bemask(input int i);
        return (i == 2) ? 2'b01 : 2'b11;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, inst, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_valid = 1'b0;
    bit          m_active[3], m_cfg[3], m_we[3], m_rvalid[3], m_fresh[3];
    int          m_age[3];
    logic [1:0]  m_be[3];
    logic [22:0] m_addr[3];
    logic [15:0] m_dq_o[3], m_rdata[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int         age;
            logic [1:0] bv;
            if (rst) begin
                m_valid     <= 1'b1;
                m_active[i] <= 1'b0;
                m_rvalid[i] <= 1'b0;
                m_rdata[i]  <= '0;
                m_addr[i]   <= '0;
                m_dq_o[i]   <= '0;
                m_fresh[i]  <= 1'b1;
            end else if (m_active[i]) begin
                age         = m_age[i] + 1;
                m_age[i]    <= age;
                m_active[i] <= (age != acc_of(i) + rec_of(i) + 1);
                m_rvalid[i] <= 1'b0;
                if (age == acc_of(i) + 1 && !m_cfg[i] && !m_we[i]) begin
                    m_rdata[i]  <= dq_i & dmask(i);
                    m_rvalid[i] <= 1'b1;
                end
            end else begin
                m_rvalid[i] <= 1'b0;
                if (req) begin
                    bv         = be & bemask(i);
                    m_fresh[i] <= 1'b0;
                    if (cfg || bv != 2'b00) begin
                        m_active[i] <= 1'b1;
                        m_age[i]    <= 0;
                        m_cfg[i]    <= cfg;
                        m_we[i]     <= we;
                        m_be[i]     <= bv;
                        m_addr[i]   <= addr;
                        if (!cfg && we) m_dq_o[i] <= wdata & dmask(i);
                    end else begin
                        m_rvalid[i] <= !we;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            for (int i = 0; i < 3; i++) begin
                logic       in_cyc, e_oe, e_we, e_cre, e_dqoe;
                logic [1:0] e_be;
                in_cyc = m_active[i] && (m_age[i] <= acc_of(i));
                e_oe = 1'b1; e_we = 1'b1; e_cre = 1'b0; e_dqoe = 1'b0; e_be = 2'b11;
                if (in_cyc) begin
                    if (m_cfg[i]) begin
                        e_we = 1'b0; e_cre = 1'b1;
                    end else if (m_we[i]) begin
                        e_we = 1'b0; e_dqoe = 1'b1; e_be = ~m_be[i];
                    end else begin
                        e_oe = 1'b0; e_be = ~m_be[i];
                    end
                end
                chk("busy", i, o_busy[i], m_active[i]);
                chk("rvalid", i, o_rvalid[i], m_rvalid[i]);
                chk("rdata", i, o_rdata[i], m_rdata[i]);
                chk("ce_n", i, o_ce_n[i], !in_cyc);
                chk("adv_n", i, o_adv_n[i], !(m_active[i] && m_age[i] == 0));
                chk("oe_n", i, o_oe_n[i], e_oe);
                chk("we_n", i, o_we_n[i], e_we);
                chk("cre", i, o_cre[i], e_cre);
                chk("dq_oe", i, o_dq_oe[i], e_dqoe);
                chk("be_n", i, o_be_n[i], e_be);
                chk("mt_clk", i, o_clk[i], 1'b0);
                if (e_dqoe || m_fresh[i]) chk("dq_o", i, o_dq_o[i], m_dq_o[i]);
                if (in_cyc || m_fresh[i]) chk("addr", i, o_addr[i], m_addr[i]);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        req = 1'b0;
        while ((o_busy[0] || o_busy[1] || o_busy[2]) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) chk("idle_timeout", -1, 1, 0);
    endtask

    task automatic sc_read();
        int oe_lo[3], rv_at[3], rv_n[3];
        logic [15:0] rd[3];
        for (int i = 0; i < 3; i++) begin oe_lo[i] = 0; rv_at[i] = -1; rv_n[i] = 0; rd[i] = '0; end
        wait_idle();
        req = 1'b1; we = 1'b0; cfg = 1'b0; be = 2'b11; addr = 23'h012345; dq_i = 16'hBEEF;
        tick();
        req = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!o_oe_n[i]) oe_lo[i]++;
                if (o_rvalid[i]) begin rv_n[i]++; rv_at[i] = k; rd[i] = o_rdata[i]; end
            end
        end
        chk("rd_oe_low", 0, oe_lo[0], 8);
        chk("rd_rv_at", 0, rv_at[0], 8);
        chk("rd_rv_n", 0, rv_n[0], 1);
        chk("rd_data", 0, rd[0], 16'hBEEF);
        chk("rd_oe_low", 1, oe_lo[1], 3);
        chk("rd_rv_at", 1, rv_at[1], 3);
        chk("rd_data", 1, rd[1], 16'hBEEF);
        chk("rd_oe_low", 2, oe_lo[2], 8);
        chk("rd_rv_at", 2, rv_at[2], 8);
        chk("rd_data", 2, rd[2], 16'h00EF);
    endtask

    task automatic sc_write();
        int we_lo = 0, oe_hi = 0, both = 0, rv_n = 0;
        logic [1:0]  ben = 2'b00;
        logic [15:0] dqo = '0;
        wait_idle();
        req = 1'b1; we = 1'b1; cfg = 1'b0; be = 2'b01; wdata = 16'hA55A; addr = 23'h000777;
        tick();
        req = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (!o_we_n[0]) begin we_lo++; ben = o_be_n[0]; end
            if (o_dq_oe[0]) begin oe_hi++; dqo = o_dq_o[0]; end
            if (o_dq_oe[0] && !o_we_n[0]) both++;
            if (o_rvalid[0]) rv_n++;
        end
        chk("wr_we_low", 0, we_lo, 8);
        chk("wr_dqoe_high", 0, oe_hi, 8);
        chk("wr_dqoe_with_we", 0, both, 8);
        chk("wr_be_n", 0, ben, 2'b10);
        chk("wr_dq_o", 0, dqo, 16'hA55A);
        chk("wr_no_rvalid", 0, rv_n, 0);
    endtask

    task automatic sc_config();
        int cre_n = 0, oe_hi = 0, we_lo = 0;
        logic [22:0] a = '0;
        logic [1:0]  ben = 2'b00;
        wait_idle();
        req = 1'b1; we = 1'b0; cfg = 1'b1; be = 2'b00; addr = 23'h081D1F;
        tick();
        req = 1'b0; cfg = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (o_cre[0]) begin cre_n++; a = o_addr[0]; ben = o_be_n[0]; end
            if (o_dq_oe[0]) oe_hi++;
            if (!o_we_n[0]) we_lo++;
        end
        chk("cfg_cre_cycles", 0, cre_n, 8);
        chk("cfg_addr", 0, a, 23'h081D1F);
        chk("cfg_be_n", 0, ben, 2'b11);
        chk("cfg_dq_oe", 0, oe_hi, 0);
        chk("cfg_we_low", 0, we_lo, 8);
    endtask

    task automatic sc_b2b();
        int acc[$];
        int run = 0, min_gap = 1000;
        logic prev_busy = 1'b0;
        wait_idle();
        req = 1'b1; we = 1'b0; cfg = 1'b0; be = 2'b11; addr = 23'h00ABCD;
        tick();
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (o_busy[0] && !prev_busy) acc.push_back(k);
            prev_busy = o_busy[0];
            if (o_ce_n[0]) run++;
            else begin
                if (run > 0 && acc.size() > 1 && run < min_gap) min_gap = run;
                run = 0;
            end
        end
        req = 1'b0;
        chk("b2b_accepts", 0, acc.size(), 3);
        if (acc.size() == 3) begin
            chk("b2b_period1", 0, acc[1] - acc[0], 10);
            chk("b2b_period2", 0, acc[2] - acc[1], 10);
        end
        chk("b2b_ce_gap", 0, min_gap, 2);
    endtask

    task automatic sc_reset_mid();
        int rv_n = 0, busy_n = 0;
        wait_idle();
        req = 1'b1; we = 1'b0; cfg = 1'b0; be = 2'b11; addr = 23'h055AA5;
        tick(); tick(); tick(); tick();  // edges 0..3: now in ACCESS cycle 3
        rst = 1'b1;
        tick();
        chk("rst_ce_n", 0, o_ce_n[0], 1'b1);
        chk("rst_oe_n", 0, o_oe_n[0], 1'b1);
        chk("rst_we_n", 0, o_we_n[0], 1'b1);
        chk("rst_adv_n", 0, o_adv_n[0], 1'b1);
        chk("rst_be_n", 0, o_be_n[0], 2'b11);
        chk("rst_cre", 0, o_cre[0], 1'b0);
        chk("rst_dq_oe", 0, o_dq_oe[0], 1'b0);
        chk("rst_addr", 0, o_addr[0], 23'h0);
        chk("rst_dq_o", 0, o_dq_o[0], 16'h0);
        chk("rst_rdata", 0, o_rdata[0], 16'h0);
        chk("rst_rvalid", 0, o_rvalid[0], 1'b0);
        chk("rst_busy", 0, o_busy[0], 1'b0);
        tick();
        rst = 1'b0; req = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_rvalid[0]) rv_n++;
            if (o_busy[0]) busy_n++;
        end
        chk("rst_no_rvalid", 0, rv_n, 0);
        chk("rst_req_ignored", 0, busy_n, 0);
    endtask

    task automatic sc_zero_be();
        int ce_lo = 0, rv_n = 0, rv_at = -1, busy_n = 0;
        logic [15:0] prev;
        wait_idle();
        prev = o_rdata[0];
        req = 1'b1; we = 1'b0; cfg = 1'b0; be = 2'b00; dq_i = 16'h1234;
        tick();
        req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!o_ce_n[0]) ce_lo++;
            if (o_busy[0]) busy_n++;
            if (o_rvalid[0]) begin rv_n++; rv_at = k; end
        end
        chk("zbe_ce_low", 0, ce_lo, 0);
        chk("zbe_busy", 0, busy_n, 0);
        chk("zbe_rv_n", 0, rv_n, 1);
        chk("zbe_rv_at", 0, rv_at, 0);
        chk("zbe_rdata", 0, o_rdata[0], prev);
    endtask

    initial begin
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        sc_read();
        sc_write();
        sc_config();
        sc_b2b();
        sc_reset_mid();
        sc_zero_be();
        for (int n = 0; n < 3000; n++) begin
            tick();
            req     = ($urandom_range(0, 3) == 0);
            we      = 1'($urandom);
            cfg     = ($urandom_range(0, 9) == 0);
            be      = 2'($urandom);
            addr    = 23'($urandom);
            wdata   = 16'($urandom);
            dq_i    = 16'($urandom);
            mt_wait = 1'($urandom);
            rst     = ($urandom_range(0, 249) == 0);
        end
        tick();
        rst = 1'b0; req = 1'b0;
        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
